tpu_sequencer: RTL and testbench

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

---
 rtl/tpu_pkg.sv | 27 ++
 rtl/tpu_out_buf.sv | 30 +++
 rtl/tpu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_tpu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU sequencer: state encoding and the TPU
// memory map used when loading operands, triggering the MAC and reading C.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_C,
    C_GAP,
    MAC,
    WAIT,
    READ_C
  } state_t;

  localparam logic [15:0] A_BASE     = 16'h0100;
  localparam logic [15:0] B_BASE     = 16'h0200;
  localparam logic [15:0] C_BASE     = 16'h0300;
  localparam logic [15:0] MAC_ADDR   = 16'h0400;
  localparam logic [15:0] ROW_STRIDE = 16'd8;

  // Address of row idx inside a region starting at base.
  function automatic logic [15:0] row_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + ({8'd0, idx} * ROW_STRIDE);
  endfunction

endpackage

// File: rtl/tpu_out_buf.sv
// Single-entry output register with valid/ready handshake; a new word may be
// loaded while the current one is being accepted, so full throughput is kept.
module tpu_out_buf #(
  parameter int DATAW = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DATAW-1:0] load_data,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  output logic             can_load
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tpu_sequencer.sv
// Job sequencer for the TPU: streams A, B and C operands into TPU memory,
// fires the MAC, waits for it to settle and streams the C result back out.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int WAIT_CYC = 3 * DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear_c,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);

  localparam int CW = $clog2(2 * DIM);
  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] LAST_AB = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_C  = CW'(2 * DIM - 1);
  localparam logic [WW-1:0] LAST_W  = WW'(WAIT_CYC - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          clear_q, clear_n;
  logic          rd_done, rd_done_n;
  logic          buf_load, buf_can_load;

  tpu_out_buf #(.DATAW(DATAW)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_data (tpu_dataOut),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .can_load  (buf_can_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      clear_q <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      wcnt    <= wcnt_n;
      clear_q <= clear_n;
      rd_done <= rd_done_n;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wcnt_n     = wcnt;
    clear_n    = clear_q;
    rd_done_n  = rd_done;
    in_ready   = 1'b0;
    tpu_r_w    = 1'b0;
    tpu_addr   = '0;
    tpu_dataIn = '0;
    buf_load   = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n   = LOAD_A;
          clear_n   = clear_c;
          cnt_n     = '0;
          wcnt_n    = '0;
          rd_done_n = 1'b0;
        end
      end

      LOAD_A, LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = ADDRW'(row_addr((state == LOAD_A) ? A_BASE : B_BASE, 8'(cnt)));
          tpu_dataIn = in_data;
          if (cnt == LAST_AB) begin
            cnt_n   = '0;
            state_n = (state == LOAD_A) ? LOAD_B : LOAD_C;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      // The C row index survives the LOAD_C/C_GAP ping-pong and steps in C_GAP.
      LOAD_C: begin
        in_ready = !clear_q;
        if (clear_q || in_valid) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = ADDRW'(row_addr(C_BASE, 8'(cnt)));
          tpu_dataIn = clear_q ? '0 : in_data;
          state_n    = C_GAP;
        end
      end

      C_GAP: begin
        if (cnt == LAST_C) begin
          cnt_n   = '0;
          state_n = MAC;
        end else begin
          cnt_n   = cnt + 1'b1;
          state_n = LOAD_C;
        end
      end

      MAC: begin
        tpu_r_w  = 1'b1;
        tpu_addr = ADDRW'(MAC_ADDR);
        wcnt_n   = '0;
        state_n  = WAIT;
      end

      WAIT: begin
        if (wcnt == LAST_W) begin
          wcnt_n  = '0;
          cnt_n   = '0;
          state_n = READ_C;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end

      // Reads only issue when the output register can take the word this cycle.
      READ_C: begin
        if (!rd_done && buf_can_load) begin
          tpu_addr = ADDRW'(row_addr(C_BASE, 8'(cnt)));
          buf_load = 1'b1;
          if (cnt == LAST_C) rd_done_n = 1'b1;
          else               cnt_n     = cnt + 1'b1;
        end
        if (rd_done && out_valid && out_ready) begin
          done      = 1'b1;
          cnt_n     = '0;
          rd_done_n = 1'b0;
          state_n   = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Scoreboard bench for tpu_sequencer: emulates TPU memory on the bus and
// compares bus writes, reads and result words against a job-level model.
module tb_tpu_sequencer;

  localparam int DIM      = 8;
  localparam int DATAW    = 64;
  localparam int ADDRW    = 16;
  localparam int WAIT_CYC = 3 * DIM;
  localparam int NC       = 2 * DIM;

  logic             clk = 1'b0;
  logic             rst_n, start, clear_c, in_valid, in_ready;
  logic             out_valid, out_ready, busy, done, tpu_r_w;
  logic [DATAW-1:0] in_data, out_data, tpu_dataIn, tpu_dataOut;
  logic [ADDRW-1:0] tpu_addr;

  always #5 clk = ~clk;

  tpu_sequencer #(.DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .WAIT_CYC(WAIT_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear_c     (clear_c),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .tpu_r_w     (tpu_r_w),
    .tpu_addr    (tpu_addr),
    .tpu_dataIn  (tpu_dataIn),
    .tpu_dataOut (tpu_dataOut)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  wr_t         exp_wr[$];
  logic [63:0] exp_out[$];
  logic [63:0] words[0:4*DIM-1];
  logic [63:0] a_mem[0:DIM-1];
  logic [63:0] b_mem[0:DIM-1];
  logic [63:0] c_mem[0:NC-1];
  int          in_idx, consumed, rd_idx, acc_cnt, done_cnt, idle_cnt;
  int          vmode, rmode, cyc, stall_left;
  bit          mac_seen, first_read, prev_wr_c, b_seen, job_clear, stalled, prev_hold;
  logic [63:0] prev_data;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // TPU memory emulation: combinational read of the C region.
  always_comb begin
    int ci;
    ci = (int'(tpu_addr) - 32'h300) / 8;
    tpu_dataOut = '0;
    if (tpu_addr >= 16'h0300 && ci < NC) tpu_dataOut = c_mem[ci];
  end

  // Input and output handshake drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (vmode)
      0:       in_valid = 1'b1;
      1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: in_valid = ($urandom_range(0, 1) == 1);
    endcase
    in_data = (in_idx < 4 * DIM) ? words[in_idx] : '0;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (!stalled && acc_cnt == 3) begin
          stalled    = 1'b1;
          stall_left = 10;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    endcase
  end

  // Monitor: samples on the falling edge, pops expectations as the DUT acts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        check_output("hold_valid", 64'(out_valid), 64'd1);
        check_output("hold_data", out_data, prev_data);
      end
      if (in_valid && in_ready) begin
        in_idx++;
        consumed++;
      end
      if (tpu_r_w) begin
        int ri;
        if (prev_wr_c) check_output("c_gap_rw", 64'(tpu_r_w), 64'd0);
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got addr %h required none", tpu_addr);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check_output("wr_addr", 64'(tpu_addr), 64'(e.addr));
          check_output("wr_data", tpu_dataIn, e.data);
        end
        ri = int'(tpu_addr[7:0]) / 8;
        prev_wr_c = 1'b0;
        case (tpu_addr[15:8])
          8'h01: if (ri < DIM) a_mem[ri] = tpu_dataIn;
          8'h02: begin
            b_seen = 1'b1;
            if (ri < DIM) b_mem[ri] = tpu_dataIn;
          end
          8'h03: begin
            prev_wr_c = 1'b1;
            if (job_clear) check_output("clear_in_ready", 64'(in_ready), 64'd0);
            if (ri < NC) c_mem[ri] = tpu_dataIn;
          end
          8'h04: begin
            mac_seen = 1'b1;
            idle_cnt = 0;
            for (int j = 0; j < NC; j++) c_mem[j] = c_mem[j] + a_mem[j % DIM] + b_mem[j % DIM];
          end
          default: ;
        endcase
      end else begin
        check_output("idle_data", tpu_dataIn, 64'd0);
        if (prev_wr_c) check_output("c_gap_addr", 64'(tpu_addr), 64'd0);
        prev_wr_c = 1'b0;
        if (tpu_addr != '0) begin
          if (!first_read) begin
            first_read = 1'b1;
            check_output("wait_len", 64'(idle_cnt), 64'(WAIT_CYC));
          end
          check_output("rd_addr", 64'(tpu_addr), 64'(32'h300 + 8 * rd_idx));
          rd_idx++;
        end else if (mac_seen && !first_read) begin
          idle_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL extra_word: got %h required none", out_data);
        end else begin
          check_output("out_word", out_data, exp_out.pop_front());
        end
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        check_output("done_last_left", 64'(exp_out.size()), 64'd0);
        check_output("done_with_accept", 64'(out_valid && out_ready), 64'd1);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic reset_vars();
    exp_wr.delete();
    exp_out.delete();
    in_idx = 0; consumed = 0; rd_idx = 0; acc_cnt = 0; done_cnt = 0; idle_cnt = 0;
    mac_seen = 0; first_read = 0; prev_wr_c = 0; b_seen = 0; stalled = 0;
    stall_left = 0; prev_hold = 0;
  endtask

  task automatic check_reset_outputs();
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_data", out_data, 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_r_w", 64'(tpu_r_w), 64'd0);
    check_output("rst_addr", 64'(tpu_addr), 64'd0);
    check_output("rst_dataIn", tpu_dataIn, 64'd0);
  endtask

  // One job: build data, push expected bus/output traffic, run, then audit.
  task automatic apply_stimulus(input bit clr, input int vm, input int rm, input bit det,
                                input bit rst_wait, input bit start_b);
    int budget;
    int exp_cons;
    reset_vars();
    job_clear = clr;
    vmode     = vm;
    rmode     = rm;
    for (int k = 0; k < 4 * DIM; k++) words[k] = det ? 64'(k + 1) : {$urandom, $urandom};
    for (int k = 0; k < DIM; k++) exp_wr.push_back('{16'h0100 + 16'(8 * k), words[k]});
    for (int k = 0; k < DIM; k++) exp_wr.push_back('{16'h0200 + 16'(8 * k), words[DIM + k]});
    for (int j = 0; j < NC; j++) exp_wr.push_back('{16'h0300 + 16'(8 * j), clr ? 64'd0 : words[2 * DIM + j]});
    exp_wr.push_back('{16'h0400, 64'd0});
    for (int j = 0; j < NC; j++)
      exp_out.push_back((clr ? 64'd0 : words[2 * DIM + j]) + words[j % DIM] + words[DIM + j % DIM]);
    exp_cons = clr ? 2 * DIM : 4 * DIM;

    @(posedge clk); #1;
    start = 1'b1; clear_c = clr;
    @(posedge clk); #1;
    start = 1'b0; clear_c = 1'b0;

    if (start_b) begin
      budget = 0;
      while (!b_seen && budget < 500) begin @(posedge clk); budget++; end
      check_output("reach_load_b", 64'(b_seen), 64'd1);
      #1;
      start = 1'b1; clear_c = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clear_c = 1'b0;
    end

    if (rst_wait) begin
      budget = 0;
      while (!mac_seen && budget < 1000) begin @(posedge clk); budget++; end
      check_output("reach_wait", 64'(mac_seen), 64'd1);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk); #1;
      reset_vars();
      rst_n = 1'b1;
      return;
    end

    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin @(posedge clk); budget++; end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done required done within 3000 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    check_output("writes_left", 64'(exp_wr.size()), 64'd0);
    check_output("words_left", 64'(exp_out.size()), 64'd0);
    check_output("done_count", 64'(done_cnt), 64'd1);
    check_output("inputs_used", 64'(consumed), 64'(exp_cons));
    check_output("reads_issued", 64'(rd_idx), 64'(NC));
    check_output("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear_c = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    vmode = 0; rmode = 0; cyc = 0; job_clear = 0;
    for (int j = 0; j < NC; j++) c_mem[j] = '0;
    for (int k = 0; k < DIM; k++) begin a_mem[k] = '0; b_mem[k] = '0; end
    reset_vars();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;

    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 0, 2, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 2, 1, 0, 0, 0);
    apply_stimulus(1, 2, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
